updown_counter_ext: RTL and testbench
=====================================

Name: updown_counter_ext

Overview:
Parametrised successor to the team's fixed 4-bit loadable up/down counter. Adds:
- configurable width
- a runtime count limit (count range 0..limit)
- wrap or saturate mode
- count enable and synchronous clear
- a registered terminal-count pulse and a sticky boundary flag

Used as a general event/interval counter in datapath and timer logic.

Parameters:
WIDTH, 4, bit width of d, limit and q (legal range 2..32).
SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate (hold at boundary).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear: q to 0, sticky flag cleared.
ld  input  1  synchronous load of d.
en  input  1  count enable.
upDown  input  1  direction: 1 = count up, 0 = count down.
d  input  WIDTH  load value.
limit  input  WIDTH  maximum count value; range is 0..limit inclusive.
q  output  WIDTH  registered count.
tc  output  1  registered terminal-count pulse, one cycle wide.
bnd  output  1  sticky flag: set on any boundary event, cleared by clr or reset.
at_max  output  1  combinational: q >= limit.
at_zero  output  1  combinational: q == 0.

Behaviour:
- Reset: rst low asynchronously forces q=0, tc=0, bnd=0, independent of clk. Release is synchronous to the design; the first count happens at the first rising edge with rst high.
- Priority each rising edge, highest first: clr, ld, en, hold.
- clr=1:
  - q=0, tc=0, bnd=0.
  - ld, en and upDown are ignored.
- ld=1 (clr=0):
  - q = d if d <= limit, else q = limit (clamped).
  - tc=0; bnd unchanged.
  - en is ignored.
- en=1, upDown=1 (clr=0, ld=0):
  - if q < limit: q = q+1.
  - if q >= limit, boundary event:
    - wrap mode: q = 0.
    - saturate mode: q = limit.
- en=1, upDown=0 (clr=0, ld=0):
  - if q > 0: q = q-1, including when q > limit.
  - if q == 0, boundary event:
    - wrap mode: q = limit.
    - saturate mode: q stays 0.
- Boundary event: tc=1 for exactly the cycle following that edge, and bnd=1.
- tc: 0 on every edge without a boundary event. Back-to-back boundary events give a continuously high tc (e.g. saturate mode held at the boundary, or limit=0).
- en=0 (clr=0, ld=0): q holds, tc=0.
- Limit changes:
  - limit is sampled each edge; there is no shadow register.
  - Lowering limit below q does not change q until the next counting or load operation.
  - Counting up from q > limit is a boundary event (wrap: 0; saturate: limit).
- limit=0: q stays 0 in both modes; every enabled count is a boundary event.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - No intermediate overflow: q+1 is only computed when q < limit <= 2^WIDTH-1.
  - limit = 2^WIDTH-1 gives full natural-range behaviour (15 to 0 wrap for WIDTH=4).
- Latency: q and tc update one cycle after the controlling inputs are sampled. at_max and at_zero follow q combinationally.
- No X propagation: all outputs are defined from reset onward. Inputs are assumed synchronous to clk.

Test Plan:
1. Reset and async behaviour (WIDTH=4, SATURATE=0, limit=15): count to q=5, then pull rst low mid-cycle -> q=0, tc=0, bnd=0 immediately, before the next edge. Release rst, en=1, upDown=1 -> q=1 after the first edge.
2. Up-count wrap (limit=9, en=1, upDown=1, start q=0): q goes 1..9, then 0. tc=1 only in the cycle q=0 after wrap; bnd=1 and stays 1. at_max=1 when q=9.
3. Down-count wrap and saturate: wrap build, limit=9, q=0, upDown=0 -> q=9, tc=1. Saturate build, same stimulus -> q stays 0, tc=1 every enabled cycle, bnd=1.
4. Load and priority:
   - limit=9, ld=1, d=6 -> q=6.
   - ld=1, d=12 -> q=9 (clamped).
   - ld=1 and en=1 together -> load wins.
   - clr=1 with ld=1, d=3 -> q=0, bnd=0.
5. Limit change below q: q=12, limit changes to 5, en=0 -> q holds 12, at_max=1. Then en=1, upDown=1 -> wrap build gives q=0, saturate build gives q=5; tc=1 in both.
6. Full-range and enable: WIDTH=8, limit=255, q=255, up -> q=0, tc=1. With en=0 for 4 cycles, q holds and tc=0. limit=0 with en=1 -> q=0 and tc=1 every cycle.

Source files
------------

// File: rtl/updown_counter_ext.sv
// Loadable up/down counter with runtime limit, wrap/saturate boundary mode,
// registered terminal-count pulse and sticky boundary flag.
module updown_counter_ext #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             en,
    input  logic             upDown,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             bnd,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             tc;
        logic             bnd;
    } state_t;

    state_t nxt;

    always_comb begin
        nxt.q   = q;
        nxt.tc  = 1'b0;
        nxt.bnd = bnd;
        if (clr) begin
            nxt.q   = '0;
            nxt.bnd = 1'b0;
        end else if (ld) begin
            nxt.q = (d <= limit) ? d : limit;
        end else if (en) begin
            if (upDown) begin
                // q+1 only when q < limit, so it can never overflow WIDTH bits
                if (q < limit) begin
                    nxt.q = q + ONE;
                end else begin
                    nxt.q   = SATURATE ? limit : '0;
                    nxt.tc  = 1'b1;
                    nxt.bnd = 1'b1;
                end
            end else begin
                if (q != '0) begin
                    nxt.q = q - ONE;
                end else begin
                    nxt.q   = SATURATE ? '0 : limit;
                    nxt.tc  = 1'b1;
                    nxt.bnd = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= '0;
            tc  <= 1'b0;
            bnd <= 1'b0;
        end else begin
            q   <= nxt.q;
            tc  <= nxt.tc;
            bnd <= nxt.bnd;
        end
    end

    assign at_max  = (q >= limit);
    assign at_zero = (q == '0);

endmodule

// File: tb/tb_updown_counter_ext.sv
// Scoreboard bench: three counter builds (4-bit wrap, 4-bit saturate, 8-bit wrap)
// share stimulus; a reference model queues expected outputs for a monitor.
module tb_updown_counter_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0, ld = 1'b0, en = 1'b0, upDown = 1'b0;
    logic [7:0] d = '0, limit = '0;

    logic [3:0] q_w, q_s;
    logic [7:0] q_8;
    logic [2:0] tc_a, bnd_a, amax_a, azero_a;

    always #5 clk = ~clk;

    updown_counter_ext #(.WIDTH(4), .SATURATE(1'b0)) u_w (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .en(en), .upDown(upDown),
        .d(d[3:0]), .limit(limit[3:0]), .q(q_w), .tc(tc_a[0]), .bnd(bnd_a[0]),
        .at_max(amax_a[0]), .at_zero(azero_a[0]));

    updown_counter_ext #(.WIDTH(4), .SATURATE(1'b1)) u_s (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .en(en), .upDown(upDown),
        .d(d[3:0]), .limit(limit[3:0]), .q(q_s), .tc(tc_a[1]), .bnd(bnd_a[1]),
        .at_max(amax_a[1]), .at_zero(azero_a[1]));

    updown_counter_ext #(.WIDTH(8), .SATURATE(1'b0)) u_8 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .en(en), .upDown(upDown),
        .d(d), .limit(limit), .q(q_8), .tc(tc_a[2]), .bnd(bnd_a[2]),
        .at_max(amax_a[2]), .at_zero(azero_a[2]));

    typedef struct packed {
        logic [2:0][7:0] q;
        logic [2:0]      tc;
        logic [2:0]      bnd;
        logic [2:0]      amax;
        logic [2:0]      azero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state per build
    int   mq[3];
    bit   mtc[3];
    bit   mb[3];
    int   wd[3]  = '{4, 4, 8};
    bit   sat[3] = '{1'b0, 1'b1, 1'b0};
    string nm[3] = '{"w4wrap", "w4sat", "w8wrap"};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] act_q(input int i);
        case (i)
            0: return {4'b0, q_w};
            1: return {4'b0, q_s};
            default: return q_8;
        endcase
    endfunction

    // apply one cycle of inputs and queue what each build should show after the edge
    task automatic drive(input bit c, input bit l, input bit e, input bit u,
                         input int dv, input int lv);
        exp_t x;
        @(negedge clk);
        clr = c; ld = l; en = e; upDown = u; d = 8'(dv); limit = 8'(lv);
        for (int i = 0; i < 3; i++) begin
            int mask = (1 << wd[i]) - 1;
            int lim  = lv & mask;
            int dd   = dv & mask;
            mtc[i] = 1'b0;
            if (c) begin
                mq[i] = 0;
                mb[i] = 1'b0;
            end else if (l) begin
                mq[i] = (dd <= lim) ? dd : lim;
            end else if (e && u) begin
                if (mq[i] < lim) mq[i] = mq[i] + 1;
                else begin
                    mq[i] = sat[i] ? lim : 0;
                    mtc[i] = 1'b1; mb[i] = 1'b1;
                end
            end else if (e) begin
                if (mq[i] > 0) mq[i] = mq[i] - 1;
                else begin
                    mq[i] = sat[i] ? 0 : lim;
                    mtc[i] = 1'b1; mb[i] = 1'b1;
                end
            end
            x.q[i]     = 8'(mq[i]);
            x.tc[i]    = mtc[i];
            x.bnd[i]   = mb[i];
            x.amax[i]  = (mq[i] >= lim);
            x.azero[i] = (mq[i] == 0);
        end
        sb.push_back(x);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s %s q", tag, nm[i]), act_q(i), 8'd0);
            chk($sformatf("%s %s tc", tag, nm[i]), {7'b0, tc_a[i]}, 8'd0);
            chk($sformatf("%s %s bnd", tag, nm[i]), {7'b0, bnd_a[i]}, 8'd0);
            mq[i] = 0; mtc[i] = 1'b0; mb[i] = 1'b0;
        end
    endtask

    // monitor: every edge with a queued expectation is compared
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s q", nm[i]), act_q(i), x.q[i]);
                chk($sformatf("%s tc", nm[i]), {7'b0, tc_a[i]}, {7'b0, x.tc[i]});
                chk($sformatf("%s bnd", nm[i]), {7'b0, bnd_a[i]}, {7'b0, x.bnd[i]});
                chk($sformatf("%s at_max", nm[i]), {7'b0, amax_a[i]}, {7'b0, x.amax[i]});
                chk($sformatf("%s at_zero", nm[i]), {7'b0, azero_a[i]}, {7'b0, x.azero[i]});
            end
        end
    end

    initial begin
        int lv;
        #2;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b1;

        // count to 5, then asynchronous reset mid-cycle
        drive(1, 0, 0, 0, 0, 15);
        repeat (5) drive(0, 0, 1, 1, 0, 15);
        @(posedge clk);
        #3;
        en = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 1, 1, 0, 15);

        // up-count wrap through limit 9
        drive(1, 0, 0, 0, 0, 9);
        repeat (11) drive(0, 0, 1, 1, 0, 9);

        // down from zero: wrap to limit / saturate at zero
        drive(1, 0, 0, 0, 0, 9);
        repeat (3) drive(0, 0, 1, 0, 0, 9);

        // load, clamp, load-over-enable, clear-over-load
        drive(0, 1, 0, 0, 6, 9);
        drive(0, 1, 0, 0, 12, 9);
        drive(0, 1, 1, 1, 2, 9);
        drive(0, 0, 1, 1, 0, 9);
        drive(1, 1, 1, 1, 3, 9);

        // limit lowered below q, then count up from above limit
        drive(0, 1, 0, 0, 12, 15);
        drive(0, 0, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 0, 5);
        drive(0, 0, 1, 1, 0, 5);
        drive(0, 1, 0, 0, 12, 15);
        drive(0, 0, 1, 0, 0, 5);

        // full natural range, enable low, then limit 0
        drive(0, 1, 0, 0, 255, 255);
        drive(0, 0, 1, 1, 0, 255);
        repeat (4) drive(0, 0, 0, 1, 0, 255);
        drive(0, 0, 1, 0, 0, 255);
        repeat (3) drive(0, 0, 1, 1, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 0, 0);

        // randomized traffic
        lv = 9;
        repeat (500) begin
            case ($urandom_range(0, 15))
                0: lv = 0;
                1: lv = 1;
                2: lv = 15;
                3: lv = 255;
                4: lv = $urandom_range(0, 255);
                5: lv = $urandom_range(0, 15);
                default: ;
            endcase
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 255), lv);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
